truth_table_sweeper: RTL
========================

// Module: truth_table_sweeper
// PURPOSE
//   Sequencer that sweeps every input combination through two external combinational
//   function units (A and B) and captures both truth tables. It also reports whether
//   the two functions are equivalent and, if not, the first differing input vector.
//   It sits between a control source (start/done) and the combinational blocks under test.
// PARAMETERS
//   N_IN    3  number of function inputs; a table holds 2**N_IN bits
//   SETTLE  1  cycles x is held before sampling (legal range 1..15)
// PORTS
//   clk           in   1          rising-edge clock
//   rst_n         in   1          asynchronous, active-low reset
//   start         in   1          request a sweep; honoured only in IDLE
//   fa            in   1          output of function unit A, driven from x
//   fb            in   1          output of function unit B, driven from x
//   x             out  N_IN       input vector to both units; x[N_IN-1] = a (MSB)
//   busy          out  1          high in DRIVE or SAMPLE
//   done          out  1          one-cycle pulse when a sweep completes
//   table_a       out  2**N_IN    table_a[i] = fa sampled with x == i
//   table_b       out  2**N_IN    table_b[i] = fb sampled with x == i
//   result_valid  out  1          tables and flags hold a complete sweep
//   equal         out  1          table_a == table_b; meaningful when result_valid = 1
//   mis_valid     out  1          at least one mismatch was found
//   mis_idx       out  N_IN       lowest index i with fa != fb
// BEHAVIOUR
//   Reset (async, rst_n = 0):
//     - state = IDLE.
//     - x, busy, done, table_a, table_b, result_valid, equal, mis_valid, mis_idx all = 0.
//   FSM states: IDLE -> DRIVE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
//   IDLE:
//     - x = 0.
//     - On start = 1: clear both tables, result_valid, mis_valid and mis_idx; set equal = 1;
//       set idx = 0 and settle count = 0; go to DRIVE.
//   DRIVE:
//     - x = idx.
//     - Stays exactly SETTLE cycles, then goes to SAMPLE.
//   SAMPLE:
//     - x = idx; the registers below update at the closing clock edge.
//     - table_a[idx] <= fa; table_b[idx] <= fb.
//     - If fa != fb: equal <= 0. If mis_valid is still 0, also mis_valid <= 1 and mis_idx <= idx.
//     - If idx == 2**N_IN-1, go to DONE. Otherwise idx <= idx+1 and go to DRIVE.
//   DONE:
//     - Lasts one cycle with done = 1 and result_valid <= 1, then returns to IDLE.
//   Latency:
//     - Start is sampled at edge k. The last SAMPLE cycle starts at edge k + 2**N_IN*(SETTLE+1) - 1.
//     - done is high in the cycle after edge k + 2**N_IN*(SETTLE+1).
//     - For N_IN=3, SETTLE=1: done is high 16 cycles after the start edge.
//   Boundaries:
//     - start while busy or in DONE is ignored; no restart and no queuing.
//     - idx wraps to 0 only through IDLE; there is no wrap inside a sweep.
//     - Tables and flags hold their values after DONE until the next accepted start.
//     - rst_n asserted mid-sweep forces IDLE immediately with all outputs at reset values.
//     - fa and fb are sampled only in SAMPLE; glitches in DRIVE have no effect.
// TESTING
//   Bench wiring: a=x[2], b=x[1], c=x[0]. The default bench uses N_IN=3, SETTLE=1.
//   1. fa = (~a|b)&(b|~c), fb = ~(~a&b)&~(~a&~b), pulse start
//      -> table_a = 8'hCD, table_b = 8'hF0, equal = 0, mis_valid = 1, mis_idx = 0,
//         done pulse 16 cycles after the start edge.
//   2. fa = fb = (~a|b)&(b|~c)
//      -> table_a = table_b = 8'hCD, equal = 1, mis_valid = 0, result_valid = 1.
//   3. fa = a, fb = a ^ (b&c)
//      -> table_a = 8'hF0, table_b = 8'h78, equal = 0, mis_idx = 3.
//   4. Hold start = 1 for 20 cycles
//      -> exactly one sweep runs; start in the DONE cycle is ignored; a second sweep starts
//         from IDLE on the next cycle.
//   5. Drop rst_n while x == 5 during a sweep
//      -> x = 0, busy = 0, tables = 0 and result_valid = 0 immediately. A following start
//         produces a correct full sweep.
//   6. SETTLE=2, same functions as test 1 -> same tables; done 24 cycles after the start edge.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Sweeps x over every input vector, capturing fa/fb into truth tables and flagging the first mismatch.
// A sweep takes 2**N_IN*(SETTLE+1) cycles plus a one-cycle DONE; start is ignored outside IDLE.
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 fa,
  input  logic                 fb,
  output logic [N_IN-1:0]      x,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_a,
  output logic [2**N_IN-1:0]   table_b,
  output logic                 result_valid,
  output logic                 equal,
  output logic                 mis_valid,
  output logic [N_IN-1:0]      mis_idx
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DRIVE   = 2'd1;
  localparam logic [1:0] SAMPLE  = 2'd2;
  localparam logic [1:0] DONE_ST = 2'd3;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST    = '1;

  logic [1:0]      state;
  logic [N_IN-1:0] idx;
  logic [3:0]      settle_cnt;

  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == DONE_ST);
  // x is derived from state so an async reset returns it to 0 at once.
  assign x    = busy ? idx : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      settle_cnt   <= '0;
      table_a      <= '0;
      table_b      <= '0;
      result_valid <= 1'b0;
      equal        <= 1'b0;
      mis_valid    <= 1'b0;
      mis_idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            table_a      <= '0;
            table_b      <= '0;
            result_valid <= 1'b0;
            mis_valid    <= 1'b0;
            mis_idx      <= '0;
            equal        <= 1'b1;
            idx          <= '0;
            settle_cnt   <= '0;
            state        <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          table_a[idx] <= fa;
          table_b[idx] <= fb;
          if (fa != fb) begin
            equal <= 1'b0;
            if (!mis_valid) begin
              mis_valid <= 1'b1;
              mis_idx   <= idx;
            end
          end
          if (idx == IDX_LAST) begin
            state <= DONE_ST;
          end else begin
            idx   <= idx + 1'b1;
            state <= DRIVE;
          end
        end
        DONE_ST: begin
          result_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
